// File: rtl/lane_rotate_engine.sv
// rtl/lane_rotate_engine.sv - slice-serial per-lane rotation engine (two DEPTH-cycle phases).
// Optional inverse rotation is compiled in with macro LANE_ROTATE_INVERSE_EN.
module lane_rotate_engine #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rotate_en,
  input  logic              mode_inv,
  output logic [ADDR_W-1:0] cnt_value,
  input  logic [24:0]       line_in,
  output logic              write_enable,
  output logic [24:0]       write_value,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  // Rotation offsets indexed by lane 5y+x.
  localparam int ROT [25] = '{ 0,  1, 62, 28, 27,
                              36, 44,  6, 55, 20,
                               3, 10, 43, 25, 39,
                              41, 45, 15, 21,  8,
                              18,  2, 61, 56, 14};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              en_prev_q;
  logic              start;
  logic              last;
  logic [24:0]       buf_q [DEPTH];
  logic [24:0]       rot_bits;

  assign start = rotate_en & ~en_prev_q;
  assign last  = (cnt_q == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      en_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_prev_q <= rotate_en;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = S_WRITE;
      end
      S_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_value    = '0;
    write_enable = 1'b0;
    write_value  = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_LOAD: begin
        cnt_value = cnt_q;
        busy      = 1'b1;
      end
      S_WRITE: begin
        cnt_value    = cnt_q;
        write_enable = 1'b1;
        write_value  = rot_bits;
        busy         = 1'b1;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Slice buffer is deliberately left out of reset; an aborted run leaves stale data.
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) buf_q[cnt_q] <= line_in;
  end

`ifdef LANE_ROTATE_INVERSE_EN
  logic mode_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      mode_q <= mode_inv;
    end
  end
`else
  logic unused_mode_inv;
  assign unused_mode_inv = mode_inv;
`endif

  // Index arithmetic wraps at ADDR_W bits, which is modulo DEPTH for power-of-two depths.
  for (genvar l = 0; l < 25; l++) begin : g_lane
    localparam logic [ADDR_W-1:0] RL = ADDR_W'(ROT[l] % DEPTH);
    logic [ADDR_W-1:0] idx;
`ifdef LANE_ROTATE_INVERSE_EN
    assign idx = mode_q ? (cnt_q + RL) : (cnt_q - RL);
`else
    assign idx = cnt_q - RL;
`endif
    assign rot_bits[l] = buf_q[idx][l];
  end

endmodule

// File: tb/tb_lane_rotate_engine.sv
// tb/tb_lane_rotate_engine.sv - directed self-checking bench for lane_rotate_engine (DEPTH 64 and 8).
module tb_lane_rotate_engine;

  localparam int ROT [25] = '{ 0,  1, 62, 28, 27,
                              36, 44,  6, 55, 20,
                               3, 10, 43, 25, 39,
                              41, 45, 15, 21,  8,
                              18,  2, 61, 56, 14};

  logic        clk = 1'b0;
  logic        rst;
  logic        rotate_en;
  logic        mode_inv;

  logic [5:0]  cnt64;
  logic [24:0] line64, wv64;
  logic        we64, busy64, done64;
  logic [2:0]  cnt8;
  logic [24:0] line8, wv8;
  logic        we8, busy8, done8;

  logic [24:0] mem64 [64];
  logic [24:0] out64 [64];
  logic [24:0] mem8  [8];
  logic [24:0] out8  [8];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign line64 = mem64[cnt64];
  assign line8  = mem8[cnt8];

  lane_rotate_engine #(.DEPTH(64)) dut (
    .clk(clk), .rst(rst), .rotate_en(rotate_en), .mode_inv(mode_inv),
    .cnt_value(cnt64), .line_in(line64), .write_enable(we64),
    .write_value(wv64), .busy(busy64), .done(done64)
  );

  lane_rotate_engine #(.DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .rotate_en(rotate_en), .mode_inv(mode_inv),
    .cnt_value(cnt8), .line_in(line8), .write_enable(we8),
    .write_value(wv8), .busy(busy8), .done(done8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mems();
    for (int i = 0; i < 64; i++) mem64[i] = '0;
    for (int i = 0; i < 8; i++) mem8[i] = '0;
  endtask

  function automatic int nonzero64();
    int n = 0;
    for (int z = 0; z < 64; z++) if (out64[z] != 0) n++;
    return n;
  endfunction

  function automatic int model_errs(input bit inv);
    int errs = 0;
    for (int z = 0; z < 64; z++) begin
      logic [24:0] e;
      for (int l = 0; l < 25; l++) begin
        int r   = ROT[l] % 64;
        int src = inv ? (z + r) % 64 : (z - r + 64) % 64;
        e[l] = mem64[src][l];
      end
      if (out64[z] !== e) errs++;
    end
    return errs;
  endfunction

  // One run from a fresh rise; k counts negedges after the start edge.
  task automatic run(input bit inv, input bit hold, input int retrig_k,
                     output int lat, output int first_we, output int n_we,
                     output int lat8, output int late_busy);
    rotate_en = 1'b0;
    mode_inv  = inv;
    for (int i = 0; i < 64; i++) out64[i] = '0;
    for (int i = 0; i < 8; i++) out8[i] = '0;
    @(negedge clk);
    @(negedge clk);
    rotate_en = 1'b1;
    lat = -1; first_we = -1; n_we = 0; lat8 = -1;
    for (int k = 1; k <= 300 && lat < 0; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) rotate_en = 1'b0;
      if (k == retrig_k - 1) rotate_en = 1'b0;
      if (k == retrig_k) rotate_en = 1'b1;
      if (k == 5) mode_inv = ~inv;
      if (we64) begin
        out64[cnt64] = wv64;
        n_we++;
        if (first_we < 0) first_we = k;
      end
      if (we8) out8[cnt8] = wv8;
      if (done8 && lat8 < 0) lat8 = k;
      if (done64) lat = k;
    end
    late_busy = 0;
    repeat (150) begin
      @(negedge clk);
      if (busy64) late_busy++;
    end
  endtask

  initial begin
    int lat, first_we, n_we, lat8, late_busy, cnt;
    int inv_slice;
    bit eff_inv;
`ifdef LANE_ROTATE_INVERSE_EN
    inv_slice = 63;
    eff_inv   = 1'b1;
`else
    inv_slice = 1;
    eff_inv   = 1'b0;
`endif
    rst = 1'b0; rotate_en = 1'b0; mode_inv = 1'b0;
    clear_mems();
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy64, 0);
    check_eq("rst_done", done64, 0);
    check_eq("rst_we", we64, 0);
    check_eq("rst_wv", wv64, 0);
    check_eq("rst_cnt", cnt64, 0);
    rst = 1'b1;

    mem64[0] = 25'h0000002;
    mem8[0]  = 25'h0000004;
    run(1'b0, 1'b0, 0, lat, first_we, n_we, lat8, late_busy);
    check_eq("fwd1_latency", lat, 129);
    check_eq("fwd1_first_we", first_we, 65);
    check_eq("fwd1_n_we", n_we, 64);
    check_eq("fwd1_slice1", out64[1], 25'h0000002);
    check_eq("fwd1_nonzero", nonzero64(), 1);
    check_eq("d8_latency", lat8, 17);
    check_eq("d8_slice6", out8[6], 25'h0000004);
    check_eq("fwd1_idle_after", late_busy, 0);

    clear_mems();
    mem64[5] = 25'h0000004;
    run(1'b0, 1'b0, 0, lat, first_we, n_we, lat8, late_busy);
    check_eq("fwd2_slice3", out64[3], 25'h0000004);
    check_eq("fwd2_nonzero", nonzero64(), 1);

    clear_mems();
    mem64[0] = 25'h0000002;
    run(1'b1, 1'b0, 0, lat, first_we, n_we, lat8, late_busy);
    check_eq("inv_slice", out64[inv_slice], 25'h0000002);
    check_eq("inv_nonzero", nonzero64(), 1);
    check_eq("inv_latency", lat, 129);

    for (int i = 0; i < 64; i++) mem64[i] = 25'($urandom);
    run(1'b0, 1'b0, 0, lat, first_we, n_we, lat8, late_busy);
    check_eq("rand_fwd_errs", model_errs(1'b0), 0);
    run(1'b1, 1'b0, 0, lat, first_we, n_we, lat8, late_busy);
    check_eq("rand_inv_errs", model_errs(eff_inv), 0);

    rotate_en = 1'b0;
    @(negedge clk);
    rotate_en = 1'b1;
    @(negedge clk);
    rotate_en = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("abort_cnt_before", cnt64, 10);
    rst = 1'b0;
    #1;
    check_eq("abort_busy", busy64, 0);
    check_eq("abort_cnt", cnt64, 0);
    check_eq("abort_we", we64, 0);
    check_eq("abort_done", done64, 0);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (we64 || busy64) cnt++;
    end
    check_eq("abort_no_activity", cnt, 0);
    run(1'b0, 1'b0, 0, lat, first_we, n_we, lat8, late_busy);
    check_eq("after_abort_latency", lat, 129);
    check_eq("after_abort_n_we", n_we, 64);

    run(1'b0, 1'b1, 100, lat, first_we, n_we, lat8, late_busy);
    check_eq("hold_latency", lat, 129);
    check_eq("hold_n_we", n_we, 64);
    check_eq("hold_no_restart", late_busy, 0);
    rotate_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
